iob_fifo_wr_arbiter: RTL and testbench

Single-clock arbiter sharing the write port of an IOb FIFO among N_REQ requesters. It grants the port in round-robin order, holds the grant for a burst of up to BURST_MAX beats, and multiplexes the winner's data and write strobe onto the FIFO write interface. It sits in the write-clock domain, directly in front of the FIFO's `data_in`/`write_en`/`full`/`level_w` pins.

---
 rtl/iob_fifo_arb_pkg.sv | 27 ++
 rtl/iob_rr_prio.sv | 31 +++
 rtl/iob_fifo_wr_arbiter.sv | 117 +++++++++++
 tb/tb_iob_fifo_wr_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_fifo_arb_pkg.sv
// Shared definitions for the IOb FIFO write-port arbiter: state encoding,
// default parameters and a constant-foldable clog2 helper.
package iob_fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int DEF_N_REQ         = 4;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ADDRESS_WIDTH = 4;
    localparam int DEF_BURST_MAX     = 4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/iob_rr_prio.sv
// Combinational round-robin priority encoder: picks the first requester at or
// after ptr (wrapping) and returns it one-hot, plus an any-request flag.
module iob_rr_prio #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic             any
);

    logic found;

    // Scan offsets 0..N_REQ-1 from ptr; the first set request wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + k) % N_REQ))) begin
                    win[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/iob_fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of an IOb FIFO.
// Optional IOB_FIFO_ARB_RESERVE_EN: only grant when a full burst fits in the FIFO.
module iob_fifo_wr_arbiter
    import iob_fifo_arb_pkg::*;
#(
    parameter int N_REQ         = DEF_N_REQ,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int BURST_MAX     = DEF_BURST_MAX
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            last,
    input  logic [N_REQ*DATA_WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]       fifo_data,
    output logic                        fifo_write_en,
    input  logic                        fifo_full,
    input  logic [ADDRESS_WIDTH-1:0]    fifo_level_w
);

    localparam int PTR_W = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);
    localparam int CNT_W = (clog2(BURST_MAX + 1) < 1) ? 1 : clog2(BURST_MAX + 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [N_REQ-1:0] win;
    logic             any_req;
    logic             grant_ok;
    logic [PTR_W-1:0] gnt_idx;
    logic             last_sel;

    iob_rr_prio #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_prio (
        .req (req),
        .ptr (ptr_q),
        .win (win),
        .any (any_req)
    );

`ifdef IOB_FIFO_ARB_RESERVE_EN
    // Headroom for a complete burst guarantees fifo_full never stalls it.
    localparam int LEVEL_LIMIT = (2 ** ADDRESS_WIDTH) - 1 - BURST_MAX;
    assign grant_ok = any_req && (int'(fifo_level_w) <= LEVEL_LIMIT);
`else
    logic unused_level;
    assign unused_level = ^fifo_level_w;
    assign grant_ok     = any_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    gnt_d      = win;
                    beat_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (fifo_write_en) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_sel || (beat_cnt_q == CNT_W'(BURST_MAX - 1))) begin
                        gnt_d   = '0;
                        ptr_d   = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant is one-hot, so the mux is a simple OR of the selected lane.
    always_comb begin
        gnt_idx       = '0;
        last_sel      = 1'b0;
        fifo_data     = '0;
        ack           = gnt_q & req & {N_REQ{~fifo_full}};
        fifo_write_en = |ack;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                gnt_idx   = PTR_W'(i);
                last_sel  = last[i];
                fifo_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign gnt = gnt_q;

endmodule

// File: tb/tb_iob_fifo_wr_arbiter.sv
// Self-checking bench for iob_fifo_wr_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a burst-level model.
module tb_iob_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int BM = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req   = '0;
    logic [N-1:0]  last  = '0;
    logic [N*DW-1:0] data_in = '0;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic [DW-1:0] fifo_data;
    logic          fifo_write_en;
    logic          fifo_full    = 1'b0;
    logic [AW-1:0] fifo_level_w = '0;

    int checkCount = 0;
    int failCount  = 0;

    // Model: current owner (-1 when nobody holds the port), beats written, next start point.
    int mOwner = -1;
    int mBeats = 0;
    int mPtr   = 0;
    logic [N-1:0]  expGnt;
    logic [N-1:0]  expAck;
    logic [DW-1:0] expData;

    iob_fifo_wr_arbiter #(
        .N_REQ         (N),
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .BURST_MAX     (BM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .last          (last),
        .data_in       (data_in),
        .gnt           (gnt),
        .ack           (ack),
        .fifo_data     (fifo_data),
        .fifo_write_en (fifo_write_en),
        .fifo_full     (fifo_full),
        .fifo_level_w  (fifo_level_w)
    );

    always #5 clk = ~clk;

    function automatic logic bitAt(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic levelOk(input logic [AW-1:0] lvl);
`ifdef IOB_FIFO_ARB_RESERVE_EN
        return int'(lvl) <= ((1 << AW) - 1 - BM);
`else
        return (lvl == lvl);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // One cycle: wait past the edge, drive inputs, return at the falling edge.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                                 input logic [N*DW-1:0] d, input logic f,
                                 input logic [AW-1:0] lvl);
        @(posedge clk);
        #2;
        req          = r;
        last         = l;
        data_in      = d;
        fifo_full    = f;
        fifo_level_w = lvl;
        @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n        = 1'b0;
        req          = '0;
        last         = '0;
        data_in      = '0;
        fifo_full    = 1'b0;
        fifo_level_w = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mOwner = -1;
            mBeats = 0;
            mPtr   = 0;
        end else if (mOwner < 0) begin
            if (req != '0 && levelOk(fifo_level_w)) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (bitAt(req, (mPtr + k) % N)) mOwner = (mPtr + k) % N;
                end
                mBeats = 0;
            end
        end else if (bitAt(req, mOwner) && !fifo_full) begin
            mBeats++;
            if (bitAt(last, mOwner) || mBeats == BM) begin
                mPtr   = (mOwner + 1) % N;
                mOwner = -1;
            end
        end
    end

    always @(negedge clk) begin
        expGnt  = '0;
        expAck  = '0;
        expData = '0;
        if (mOwner >= 0) begin
            expGnt  = N'(1) << mOwner;
            expData = DW'(data_in >> (mOwner * DW));
            if (bitAt(req, mOwner) && !fifo_full) expAck = expGnt;
        end
        checkOutput("model_gnt", 32'(gnt), 32'(expGnt));
        checkOutput("model_ack", 32'(ack), 32'(expAck));
        checkOutput("model_wr_en", 32'(fifo_write_en), 32'(|expAck));
        if (expAck != '0 || mOwner < 0) checkOutput("model_data", 32'(fifo_data), 32'(expData));
    end

    initial begin
        logic [31:0] expect32;
        logic [N-1:0] r;
        logic [N-1:0] l;
        logic [N*DW-1:0] d;

        #12;
        checkOutput("reset_gnt", 32'(gnt), 32'h0);
        checkOutput("reset_data", 32'(fifo_data), 32'h0);
        doReset();

        // Single requester, three beats ending on last.
        applyStimulus(4'b0001, 4'b0000, 32'h000000A1, 1'b0, 4'd0);
        checkOutput("t1_idle_gnt", 32'(gnt), 32'h0);
        applyStimulus(4'b0001, 4'b0000, 32'h000000A1, 1'b0, 4'd0);
        checkOutput("t1_gnt", 32'(gnt), 32'h1);
        checkOutput("t1_ack1", 32'(ack), 32'h1);
        checkOutput("t1_data1", 32'(fifo_data), 32'hA1);
        applyStimulus(4'b0001, 4'b0000, 32'h000000A2, 1'b0, 4'd0);
        checkOutput("t1_data2", 32'(fifo_data), 32'hA2);
        applyStimulus(4'b0001, 4'b0001, 32'h000000A3, 1'b0, 4'd0);
        checkOutput("t1_data3", 32'(fifo_data), 32'hA3);
        checkOutput("t1_wr3", 32'(fifo_write_en), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0, 4'd0);
        checkOutput("t1_release", 32'(gnt), 32'h0);

        // All requesting, no last: bursts of BM beats with one idle cycle, order 0,1,2,3,0.
        doReset();
        for (int c = 0; c < 25; c++) begin
            applyStimulus(4'b1111, 4'b0000, $urandom, 1'b0, 4'd0);
            expect32 = (c % 5 == 0) ? 32'h0 : (32'h1 << ((c / 5) % 4));
            checkOutput("t2_gnt", 32'(gnt), expect32);
            checkOutput("t2_wr", 32'(fifo_write_en), (c % 5 == 0) ? 32'h0 : 32'h1);
        end

        // fifo_full for five cycles in the middle of a burst.
        doReset();
        for (int c = 0; c < 11; c++) begin
            applyStimulus(4'b0001, 4'b0000, $urandom, (c >= 3 && c <= 7), 4'd0);
            checkOutput("t3_wr", 32'(fifo_write_en),
                        (c == 1 || c == 2 || c == 8 || c == 9) ? 32'h1 : 32'h0);
            checkOutput("t3_gnt", 32'(gnt), (c >= 1 && c <= 9) ? 32'h1 : 32'h0);
        end

        // Requester 2 drops its request for two cycles inside its burst.
        doReset();
        applyStimulus(4'b0100, 4'b0000, 32'h00330000, 1'b0, 4'd0);
        applyStimulus(4'b0100, 4'b0000, 32'h00340000, 1'b0, 4'd0);
        checkOutput("t4_gnt", 32'(gnt), 32'h4);
        checkOutput("t4_data", 32'(fifo_data), 32'h34);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0, 4'd0);
            checkOutput("t4_hold_gnt", 32'(gnt), 32'h4);
            checkOutput("t4_hold_wr", 32'(fifo_write_en), 32'h0);
        end
        applyStimulus(4'b0100, 4'b0100, 32'h00350000, 1'b0, 4'd0);
        checkOutput("t4_last_wr", 32'(fifo_write_en), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0, 4'd0);
        checkOutput("t4_release", 32'(gnt), 32'h0);

        // Level-based reservation.
        doReset();
`ifdef IOB_FIFO_ARB_RESERVE_EN
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0001, 4'b0000, 32'h0, 1'b0, 4'd12);
            checkOutput("t5_blocked", 32'(gnt), 32'h0);
        end
        applyStimulus(4'b0001, 4'b0000, 32'h0, 1'b0, 4'd11);
        checkOutput("t5_decide", 32'(gnt), 32'h0);
        applyStimulus(4'b0001, 4'b0000, 32'h0, 1'b0, 4'd11);
        checkOutput("t5_grant", 32'(gnt), 32'h1);
`else
        applyStimulus(4'b0001, 4'b0000, 32'h0, 1'b0, 4'd15);
        checkOutput("t5_decide", 32'(gnt), 32'h0);
        applyStimulus(4'b0001, 4'b0000, 32'h0, 1'b0, 4'd15);
        checkOutput("t5_grant", 32'(gnt), 32'h1);
`endif

        // Reset pulsed low mid-burst of requester 1.
        doReset();
        applyStimulus(4'b0010, 4'b0000, 32'h00005500, 1'b0, 4'd0);
        applyStimulus(4'b0010, 4'b0000, 32'h00005600, 1'b0, 4'd0);
        checkOutput("t6_gnt", 32'(gnt), 32'h2);
        applyStimulus(4'b0010, 4'b0000, 32'h00005700, 1'b0, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_gnt", 32'(gnt), 32'h0);
        checkOutput("t6_rst_ack", 32'(ack), 32'h0);
        checkOutput("t6_rst_wr", 32'(fifo_write_en), 32'h0);
        checkOutput("t6_rst_data", 32'(fifo_data), 32'h0);
        @(posedge clk);
        #2;
        req = 4'b1111;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_after_idle", 32'(gnt), 32'h0);
        applyStimulus(4'b1111, 4'b0000, 32'h0, 1'b0, 4'd0);
        checkOutput("t6_first_gnt", 32'(gnt), 32'h1);

        // Randomized traffic, checked by the model every cycle.
        doReset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                r[i] = ($urandom_range(0, 99) < 60);
                l[i] = ($urandom_range(0, 99) < 30);
            end
            d = {$urandom};
            applyStimulus(r, l, d, ($urandom_range(0, 99) < 15), AW'($urandom_range(0, 15)));
        end

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
